// File: rtl/pixel_scan_pkg.sv
// Shared types and constants for the pixel window scan sequencer.
// Marker bit positions apply to both data_start and data_end.
package pixel_scan_pkg;

    localparam int IDX_W         = 11;
    localparam int CH_W          = 4;
    localparam int COLS_PER_BEAT = 5;
    localparam int ROWS_PER_BEAT = 2;

    localparam int MARK_CH  = 0;
    localparam int MARK_JOB = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/pixel_scan_ctrl_counter_chain.sv
// Cascaded column-group / row-pair / channel counters for the scan sequencer.
// nxt_* is the position that will be current after this edge (clr wins over adv).
module scan_counter_chain #(
    parameter int IDX_W    = pixel_scan_pkg::IDX_W,
    parameter int CH_W     = pixel_scan_pkg::CH_W,
    parameter int COL_STEP = pixel_scan_pkg::COLS_PER_BEAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [IDX_W-1:0] cfg_rows,
    input  logic [IDX_W-1:0] cfg_cols,
    input  logic [CH_W-1:0]  cfg_channels,
    output logic [IDX_W-1:0] nxt_col,
    output logic [IDX_W-1:0] nxt_row,
    output logic [CH_W-1:0]  nxt_ch
);
    localparam logic [IDX_W-1:0] COL_STEP_I = IDX_W'(COL_STEP);
    localparam logic [IDX_W-1:0] ROW_STEP_I = IDX_W'(pixel_scan_pkg::ROWS_PER_BEAT);
    localparam logic [IDX_W:0]   COL_STEP_W = (IDX_W+1)'(COL_STEP);
    localparam logic [IDX_W:0]   ROW_STEP_W = (IDX_W+1)'(pixel_scan_pkg::ROWS_PER_BEAT);
    localparam logic [CH_W-1:0]  CH_ONE     = CH_W'(1);
    localparam logic [CH_W:0]    CH_ONE_W   = (CH_W+1)'(1);

    logic [IDX_W-1:0] col, row;
    logic [CH_W-1:0]  ch;
    logic             col_tc, row_tc, ch_tc;

    // Terminal compares are done one bit wider so col+5 / row+2 cannot wrap.
    assign col_tc = ({1'b0, col} + COL_STEP_W) >= {1'b0, cfg_cols};
    assign row_tc = ({1'b0, row} + ROW_STEP_W) >= {1'b0, cfg_rows};
    assign ch_tc  = ({1'b0, ch} + CH_ONE_W) >= {1'b0, cfg_channels};

    always_comb begin
        nxt_col = col;
        nxt_row = row;
        nxt_ch  = ch;
        if (clr) begin
            nxt_col = '0;
            nxt_row = '0;
            nxt_ch  = '0;
        end else if (adv) begin
            if (col_tc) begin
                nxt_col = '0;
                if (row_tc) begin
                    nxt_row = '0;
                    nxt_ch  = ch_tc ? '0 : ch + CH_ONE;
                end else begin
                    nxt_row = row + ROW_STEP_I;
                end
            end else begin
                nxt_col = col + COL_STEP_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else begin
            col <= nxt_col;
            row <= nxt_row;
            ch  <= nxt_ch;
        end
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Job sequencer for the dual-lane pixel window consumer: walks channel,
// row pair and 5-column group, issuing one registered beat per handshake.
module pixel_scan_ctrl #(
    parameter int IDX_W         = pixel_scan_pkg::IDX_W,
    parameter int CH_W          = pixel_scan_pkg::CH_W,
    parameter int COLS_PER_BEAT = pixel_scan_pkg::COLS_PER_BEAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] cfg_rows,
    input  logic [IDX_W-1:0] cfg_cols,
    input  logic [CH_W-1:0]  cfg_channels,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] row_idx1,
    output logic [IDX_W-1:0] col_idx1,
    output logic [IDX_W-1:0] row_idx2,
    output logic [IDX_W-1:0] col_idx2,
    output logic             lane2_en,
    output logic [CH_W-1:0]  channel_num,
    output logic [1:0]       data_start,
    output logic [1:0]       data_end
);
    import pixel_scan_pkg::*;

    localparam logic [IDX_W:0] ONE_W      = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] ROW_STEP_W = (IDX_W+1)'(ROWS_PER_BEAT);
    localparam logic [IDX_W:0] COL_STEP_W = (IDX_W+1)'(COLS_PER_BEAT);
    localparam logic [CH_W:0]  CH_ONE_W   = (CH_W+1)'(1);

    scan_state_e      state, state_d;
    logic [IDX_W-1:0] lat_rows, lat_cols;
    logic [CH_W-1:0]  lat_ch;
    logic [IDX_W-1:0] use_rows, use_cols;
    logic [CH_W-1:0]  use_ch;
    logic             take, clr, adv, load_beat, cfg_zero, accept;
    logic [IDX_W-1:0] nxt_col, nxt_row;
    logic [CH_W-1:0]  nxt_ch;
    logic             n_lane2, n_first, n_ch_end, n_ch_last;

    // Beat 0 is built in the same edge the config is latched, so IDLE looks at the live inputs.
    assign use_rows = (state == ST_IDLE) ? cfg_rows     : lat_rows;
    assign use_cols = (state == ST_IDLE) ? cfg_cols     : lat_cols;
    assign use_ch   = (state == ST_IDLE) ? cfg_channels : lat_ch;
    assign cfg_zero = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_channels == '0);
    assign accept   = out_valid && out_ready;

    scan_counter_chain #(
        .IDX_W    (IDX_W),
        .CH_W     (CH_W),
        .COL_STEP (COLS_PER_BEAT)
    ) u_chain (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .adv          (adv),
        .cfg_rows     (use_rows),
        .cfg_cols     (use_cols),
        .cfg_channels (use_ch),
        .nxt_col      (nxt_col),
        .nxt_row      (nxt_row),
        .nxt_ch       (nxt_ch)
    );

    always_comb begin
        n_lane2   = ({1'b0, nxt_row} + ONE_W) < {1'b0, use_rows};
        n_first   = (nxt_col == '0) && (nxt_row == '0);
        n_ch_end  = (({1'b0, nxt_col} + COL_STEP_W) >= {1'b0, use_cols}) &&
                    (({1'b0, nxt_row} + ROW_STEP_W) >= {1'b0, use_rows});
        n_ch_last = ({1'b0, nxt_ch} + CH_ONE_W) >= {1'b0, use_ch};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        take      = 1'b0;
        clr       = 1'b0;
        adv       = 1'b0;
        load_beat = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    take = 1'b1;
                    if (cfg_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_RUN;
                        clr       = 1'b1;
                        load_beat = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (data_end[MARK_JOB]) begin
                        state_d = ST_DONE;
                    end else begin
                        adv       = 1'b1;
                        load_beat = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rows <= '0;
            lat_cols <= '0;
            lat_ch   <= '0;
        end else if (take) begin
            lat_rows <= cfg_rows;
            lat_cols <= cfg_cols;
            lat_ch   <= cfg_channels;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            row_idx1    <= '0;
            col_idx1    <= '0;
            row_idx2    <= '0;
            col_idx2    <= '0;
            lane2_en    <= 1'b0;
            channel_num <= '0;
            data_start  <= '0;
            data_end    <= '0;
        end else begin
            done <= (state == ST_DONE);
            if (take)                busy <= 1'b1;
            else if (state == ST_DONE) busy <= 1'b0;

            if (load_beat) begin
                out_valid             <= 1'b1;
                row_idx1              <= nxt_row;
                col_idx1              <= nxt_col;
                lane2_en              <= n_lane2;
                row_idx2              <= n_lane2 ? nxt_row + IDX_W'(1) : '0;
                col_idx2              <= n_lane2 ? nxt_col : '0;
                channel_num           <= nxt_ch;
                data_start[MARK_CH]   <= n_first;
                data_start[MARK_JOB]  <= n_first && (nxt_ch == '0);
                data_end[MARK_CH]     <= n_ch_end;
                data_end[MARK_JOB]    <= n_ch_end && n_ch_last;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
